// File: rtl/q6_shifter_pkg.sv
// Shared types and constants for the 4-bit one-hot-select shifter.
// The shift-amount encoding is used by the combinational datapath.
package q6_shifter_pkg;

    localparam int DATA_W = 4;
    localparam int SEL_W  = 4;

    typedef logic [1:0] shamt_t;

    localparam shamt_t SH0 = 2'd0;
    localparam shamt_t SH1 = 2'd1;
    localparam shamt_t SH2 = 2'd2;
    localparam shamt_t SH3 = 2'd3;

endpackage

// File: rtl/q6_shifter_comb.sv
// Combinational core: decode the one-hot select, flag illegal selects,
// and rotate or shift the 4-bit word left by the decoded amount.
module shifter4_comb
    import q6_shifter_pkg::*;
#(
    parameter bit ROTATE = 1'b1
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] result,
    output logic              sel_err
);

    shamt_t            amount;
    logic              legal;
    logic [DATA_W-1:0] shifted;

    // sel is {i,j,k,l}; anything other than a single set bit is illegal
    always_comb begin
        amount = SH0;
        legal  = 1'b1;
        case (sel)
            4'b0001: amount = SH0;
            4'b0010: amount = SH1;
            4'b0100: amount = SH2;
            4'b1000: amount = SH3;
            default: legal  = 1'b0;
        endcase
    end

    always_comb begin
        shifted = '0;
        case (amount)
            SH0: shifted = data_in;
            SH1: shifted = ROTATE ? {data_in[2:0], data_in[3]}
                                  : {data_in[2:0], 1'b0};
            SH2: shifted = ROTATE ? {data_in[1:0], data_in[3:2]}
                                  : {data_in[1:0], 2'b00};
            SH3: shifted = ROTATE ? {data_in[0], data_in[3:1]}
                                  : {data_in[0], 3'b000};
            default: shifted = '0;
        endcase
    end

    always_comb begin
        result  = legal ? shifted : '0;
        sel_err = ~legal;
    end

endmodule

// File: rtl/q6_shifter.sv
// Top level: registers the combinational shifter result and its select-error
// flag, one cycle of latency, with asynchronous active-high clear.
module q6_shifter
    import q6_shifter_pkg::*;
#(
    parameter bit ROTATE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    input  logic i,
    input  logic j,
    input  logic k,
    input  logic l,
    output logic W,
    output logic X,
    output logic Y,
    output logic Z,
    output logic sel_err
);

    logic [DATA_W-1:0] comb_r;
    logic              comb_err;
    logic [DATA_W-1:0] r_d;
    logic [DATA_W-1:0] r_q;
    logic              err_d;
    logic              err_q;

    shifter4_comb #(
        .ROTATE (ROTATE)
    ) u_comb (
        .data_in (({A, B, C, D})),
        .sel     (({i, j, k, l})),
        .result  (comb_r),
        .sel_err (comb_err)
    );

    always_comb begin
        r_d   = comb_r;
        err_d = comb_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= '0;
            err_q <= 1'b0;
        end else begin
            r_q   <= r_d;
            err_q <= err_d;
        end
    end

    assign {W, X, Y, Z} = r_q;
    assign sel_err      = err_q;

endmodule

// File: tb/tb_q6_shifter.sv
// Self-checking bench: a rotate instance and a shift instance share inputs and
// are compared against an arithmetic reference model.
module tb_q6_shifter;

    logic clk;
    logic rst;
    logic A, B, C, D;
    logic i, j, k, l;
    logic W_r, X_r, Y_r, Z_r, err_r;
    logic W_s, X_s, Y_s, Z_s, err_s;

    int tests_run;
    int tests_failed;

    q6_shifter #(.ROTATE(1'b1)) dut_rot (
        .clk(clk), .rst(rst),
        .A(A), .B(B), .C(C), .D(D),
        .i(i), .j(j), .k(k), .l(l),
        .W(W_r), .X(X_r), .Y(Y_r), .Z(Z_r), .sel_err(err_r)
    );

    q6_shifter #(.ROTATE(1'b0)) dut_shf (
        .clk(clk), .rst(rst),
        .A(A), .B(B), .C(C), .D(D),
        .i(i), .j(j), .k(k), .l(l),
        .W(W_s), .X(X_s), .Y(Y_s), .Z(Z_s), .sel_err(err_s)
    );

    always #5 clk = ~clk;

    // Returns {sel_err, result}; select bit n (l=bit0 .. i=bit3) means amount n
    function automatic logic [4:0] model(input logic [3:0] d, input logic [3:0] sel,
                                         input bit rot);
        int n;
        int amt;
        int v;
        n   = 0;
        amt = 0;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                n++;
                amt = b;
            end
        end
        if (n != 1) return 5'b10000;
        v = int'(d) << amt;
        if (rot) v = v | (v >> 4);
        return {1'b0, 4'(v & 15)};
    endfunction

    function automatic logic [4:0] obs_rot();
        return {err_r, W_r, X_r, Y_r, Z_r};
    endfunction

    function automatic logic [4:0] obs_shf();
        return {err_s, W_s, X_s, Y_s, Z_s};
    endfunction

    task automatic applyStimulus(input logic [3:0] d, input logic [3:0] sel);
        @(negedge clk);
        {A, B, C, D} = d;
        {i, j, k, l} = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        tests_run++;
        if (obs_rot() !== 5'b0 || obs_shf() !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_init: got rot=%b shf=%b expected 00000", obs_rot(), obs_shf());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [3:0] dv [7]  = '{4'b1000, 4'b1110, 4'b1111, 4'b0111, 4'b0111, 4'b0101, 4'b0111};
        logic [3:0] sv [7]  = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b0010};
        logic [3:0] er [7]  = '{4'b1000, 4'b1101, 4'b1111, 4'b1101, 4'b1011, 4'b1010, 4'b1110};
        logic [3:0] es [7]  = '{4'b1000, 4'b1100, 4'b1110, 4'b1100, 4'b1000, 4'b1000, 4'b1110};
        for (int t = 0; t < 7; t++) begin
            applyStimulus(dv[t], sv[t]);
            tests_run++;
            if (obs_rot() !== {1'b0, er[t]} || obs_shf() !== {1'b0, es[t]}) begin
                tests_failed++;
                $display("[TB] FAIL directed_%0d: got rot=%b shf=%b expected rot=%b shf=%b",
                         t, obs_rot(), obs_shf(), {1'b0, er[t]}, {1'b0, es[t]});
            end
        end
    endtask

    task automatic test_illegal_select();
        logic [3:0] sv  [4] = '{4'b0000, 4'b0110, 4'b1111, 4'b0001};
        logic [4:0] exp [4] = '{5'b10000, 5'b10000, 5'b10000, 5'b01011};
        for (int t = 0; t < 4; t++) begin
            applyStimulus(4'b1011, sv[t]);
            tests_run++;
            if (obs_rot() !== exp[t] || obs_shf() !== exp[t]) begin
                tests_failed++;
                $display("[TB] FAIL illegal_sel_%0d: got rot=%b shf=%b expected %b",
                         t, obs_rot(), obs_shf(), exp[t]);
            end
        end
    endtask

    task automatic test_hold();
        applyStimulus(4'b1110, 4'b0010);
        #1;
        {A, B, C, D} = 4'b0101;
        {i, j, k, l} = 4'b1000;
        #2;
        tests_run++;
        if (obs_rot() !== 5'b01101 || obs_shf() !== 5'b01100) begin
            tests_failed++;
            $display("[TB] FAIL hold_between_edges: got rot=%b shf=%b expected rot=01101 shf=01100",
                     obs_rot(), obs_shf());
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (obs_rot() !== 5'b01010 || obs_shf() !== 5'b01000) begin
            tests_failed++;
            $display("[TB] FAIL hold_next_edge: got rot=%b shf=%b expected rot=01010 shf=01000",
                     obs_rot(), obs_shf());
        end
    endtask

    task automatic test_reset_mid();
        applyStimulus(4'b1000, 4'b0001);
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (obs_rot() !== 5'b0 || obs_shf() !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_async: got rot=%b shf=%b expected 00000", obs_rot(), obs_shf());
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (obs_rot() !== 5'b0 || obs_shf() !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_held: got rot=%b shf=%b expected 00000", obs_rot(), obs_shf());
        end
        @(negedge clk);
        {A, B, C, D} = 4'b0111;
        {i, j, k, l} = 4'b0100;
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (obs_rot() !== 5'b01101 || obs_shf() !== 5'b01100) begin
            tests_failed++;
            $display("[TB] FAIL reset_release: got rot=%b shf=%b expected rot=01101 shf=01100",
                     obs_rot(), obs_shf());
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] d;
        logic [3:0] sel;
        for (int t = 0; t < 200; t++) begin
            d = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) sel = 4'($urandom_range(0, 15));
            else                          sel = 4'(1 << $urandom_range(0, 3));
            applyStimulus(d, sel);
            tests_run++;
            if (obs_rot() !== model(d, sel, 1'b1) || obs_shf() !== model(d, sel, 1'b0)) begin
                tests_failed++;
                $display("[TB] FAIL random_%0d d=%b sel=%b: got rot=%b shf=%b expected rot=%b shf=%b",
                         t, d, sel, obs_rot(), obs_shf(), model(d, sel, 1'b1), model(d, sel, 1'b0));
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clk = 1'b0;
        rst = 1'b0;
        {A, B, C, D} = 4'b0;
        {i, j, k, l} = 4'b0;
        #2;
        test_reset();
        test_directed();
        test_illegal_select();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
